// File: rtl/inv_bwt.sv
// ============================================================================
// inv_bwt : inverse Burrows-Wheeler transform engine
// ----------------------------------------------------------------------------
// Decodes a block of n symbols from its BWT last column (L) and the primary
// index. Flow: CLEAR (zero histogram) -> COUNT (histogram + stable ranks) ->
// PREFIX (exclusive prefix sum) -> WALK (LF-mapping walk, back to front).
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   en         : load strobe, writes in_string to L_mem[adr] (idle only)
//   adr        : load address while en=1, read address for outstring otherwise
//   in_string  : L symbol to load
//   length     : block length n, sampled at start
//   prim_idx   : primary row index, sampled at start
//   start      : single-cycle decode request (idle only)
//   outstring  : registered decoded symbol O_mem[adr]
//   busy       : high while decoding
//   done_flag  : decode finished (held until next accepted en/start)
//   err_flag   : decode rejected, prim_idx >= length
// Revision: 1.0
// ============================================================================
`default_nettype none

module inv_bwt #(
  parameter int MAXLEN = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [9:0] adr,
  input  logic [7:0] in_string,
  input  logic [9:0] length,
  input  logic [9:0] prim_idx,
  input  logic       start,
  output logic [7:0] outstring,
  output logic       busy,
  output logic       done_flag,
  output logic       err_flag
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    COUNT  = 3'd2,
    PREFIX = 3'd3,
    WALK   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state, state_nx;

  // Shared step counter: histogram bin in CLEAR/PREFIX, symbol index in
  // COUNT, output position k in WALK.
  logic [9:0] ctr;
  logic [9:0] row;    // current sorted-rotation row during WALK
  logic [9:0] acc;    // running prefix sum
  logic [9:0] n_len;  // latched block length

  logic [7:0] l_mem [0:MAXLEN];
  logic [7:0] o_mem [0:MAXLEN];
  logic [9:0] rank  [0:MAXLEN];
  logic [9:0] cnt   [0:255];

  logic       idle_like;
  logic       bad_start;
  logic [7:0] sym_i;
  logic [7:0] sym_r;

  assign idle_like = (state == IDLE) || (state == DONE);
  // Zero length or an out-of-range primary row finishes without decoding.
  assign bad_start = (length == 10'd0) || (prim_idx >= length);
  assign sym_i     = l_mem[ctr];
  assign sym_r     = l_mem[row];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    case (state)
      IDLE, DONE: begin
        busy = 1'b0;
        if (en) begin
          state_nx = IDLE;
        end else if (start) begin
          state_nx = bad_start ? DONE : CLEAR;
        end
      end
      CLEAR:   if (ctr == 10'd255)          state_nx = COUNT;
      COUNT:   if (ctr == n_len - 10'd1)    state_nx = PREFIX;
      PREFIX:  if (ctr == 10'd255)          state_nx = WALK;
      WALK:    if (ctr == 10'd0)            state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr       <= 10'd0;
      row       <= 10'd0;
      acc       <= 10'd0;
      n_len     <= 10'd0;
      outstring <= 8'd0;
      done_flag <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (en) begin
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
          end else begin
            outstring <= o_mem[adr];
            if (start) begin
              n_len     <= length;
              row       <= prim_idx;
              ctr       <= 10'd0;
              acc       <= 10'd0;
              done_flag <= bad_start;
              err_flag  <= (length != 10'd0) && (prim_idx >= length);
            end else if (state == DONE) begin
              // A normal decode raises done one edge after entering DONE.
              done_flag <= 1'b1;
            end
          end
        end
        CLEAR: ctr <= (ctr == 10'd255) ? 10'd0 : ctr + 10'd1;
        COUNT: ctr <= (ctr == n_len - 10'd1) ? 10'd0 : ctr + 10'd1;
        PREFIX: begin
          acc <= acc + cnt[ctr[7:0]];
          // Hand over to WALK with k = n-1.
          ctr <= (ctr == 10'd255) ? n_len - 10'd1 : ctr + 10'd1;
        end
        WALK: begin
          // LF mapping: next row = C[L[r]] + rank[r]
          row <= cnt[sym_r] + rank[row];
          ctr <= ctr - 10'd1;
        end
        default: ;
      endcase
    end
  end

  // Storage arrays are deliberately not reset. Reset forces state to IDLE,
  // so no decode-phase writes happen while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n && idle_like && en) begin
      l_mem[adr] <= in_string;
    end
    case (state)
      CLEAR:  cnt[ctr[7:0]] <= 10'd0;
      COUNT: begin
        rank[ctr]  <= cnt[sym_i];
        cnt[sym_i] <= cnt[sym_i] + 10'd1;
      end
      PREFIX: cnt[ctr[7:0]] <= acc;   // exclusive prefix: old accumulator
      WALK:   o_mem[ctr]    <= sym_r;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_inv_bwt.sv
// ============================================================================
// tb_inv_bwt : self-checking bench for inv_bwt
// ----------------------------------------------------------------------------
// Directed scenarios plus random blocks; the reference BWT is computed by
// sorting all rotations of the original string.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inv_bwt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [9:0] adr;
  logic [7:0] in_string;
  logic [9:0] length;
  logic [9:0] prim_idx;
  logic       start;
  logic [7:0] outstring;
  logic       busy;
  logic       done_flag;
  logic       err_flag;

  int total = 0;
  int bad   = 0;

  byte unsigned src [0:1023];
  byte unsigned lcol[0:1023];
  int           sa  [0:1023];

  inv_bwt #(.MAXLEN(1023)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .adr(adr), .in_string(in_string),
    .length(length), .prim_idx(prim_idx), .start(start),
    .outstring(outstring), .busy(busy), .done_flag(done_flag),
    .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input int v);
    @(negedge clk);
    en = 1'b1; adr = 10'(a); in_string = 8'(v);
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic rd(input int a, output int v);
    @(negedge clk);
    en = 1'b0; adr = 10'(a);
    @(posedge clk); #1;
    v = int'(outstring);
  endtask

  // Runs a decode; returns the edge index (start edge = 0) at which done_flag
  // is first seen, or -1. Optional disturbance pulses and mid-run reset.
  task automatic decode(input int n, input int p, input bit disturb,
                        input int abort_at, output int done_cyc);
    done_cyc = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (abort_at >= 0 && c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done_flag), 0);
        check("rst_err", int'(err_flag), 0);
        check("rst_out", int'(outstring), 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cyc = -2;
        return;
      end
      length   = 10'(n);
      prim_idx = 10'(p);
      start    = (c == 0) || (disturb && c == 100);
      en       = disturb && (c == 258);
      adr      = 10'd0;
      in_string = 8'h51;
      @(posedge clk); #1;
      start = 1'b0; en = 1'b0;
      if (c == 50) check("busy_mid", int'(busy), 1);
      if (done_flag) begin
        done_cyc = c;
        return;
      end
    end
  endtask

  function automatic bit rot_less(input int a, input int b, input int n);
    for (int i = 0; i < n; i++) begin
      if (src[(a + i) % n] != src[(b + i) % n])
        return src[(a + i) % n] < src[(b + i) % n];
    end
    return a < b;
  endfunction

  // Forward BWT of src[0..n-1] into lcol, returns primary index.
  function automatic int bwt_encode(input int n);
    int prim = 0;
    for (int i = 0; i < n; i++) sa[i] = i;
    for (int i = 1; i < n; i++) begin
      int key = sa[i];
      int j = i - 1;
      while (j >= 0 && rot_less(key, sa[j], n)) begin
        sa[j + 1] = sa[j];
        j--;
      end
      sa[j + 1] = key;
    end
    for (int i = 0; i < n; i++) begin
      lcol[i] = src[(sa[i] + n - 1) % n];
      if (sa[i] == 0) prim = i;
    end
    return prim;
  endfunction

  task automatic random_block(input int n, input string tag);
    int p, dc, v, mism;
    for (int i = 0; i < n; i++) src[i] = 8'($urandom_range(0, 255));
    p = bwt_encode(n);
    for (int i = 0; i < n; i++) load(i, lcol[i]);
    decode(n, p, 1'b0, -1, dc);
    check({tag, "_done_cyc"}, dc, 2 * n + 513);
    mism = 0;
    for (int i = 0; i < n; i++) begin
      rd(i, v);
      if (v != int'(src[i])) mism++;
    end
    check({tag, "_mismatches"}, mism, 0);
  endtask

  task automatic check_banana(input string tag);
    string ref_s;
    int v;
    ref_s = "BANANA";
    for (int i = 0; i < 6; i++) begin
      rd(i, v);
      check($sformatf("%s_chr%0d", tag, i), v, int'(ref_s[i]));
    end
  endtask

  task automatic load_nnbaaa();
    string l_s;
    l_s = "NNBAAA";
    for (int i = 0; i < 6; i++) load(i, int'(l_s[i]));
  endtask

  initial begin
    int dc, v;
    rst_n = 1'b0; en = 1'b0; start = 1'b0; adr = '0;
    in_string = '0; length = '0; prim_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", int'(outstring), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done_flag), 0);
    check("reset_err", int'(err_flag), 0);
    @(negedge clk); rst_n = 1'b1;

    // BANANA
    load_nnbaaa();
    decode(6, 3, 1'b0, -1, dc);
    check("banana_done_cyc", dc, 525);
    check("banana_err", int'(err_flag), 0);
    check_banana("banana");

    // Rejected start: prim_idx == length
    @(negedge clk);
    length = 10'd6; prim_idx = 10'd6; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    check("err_done", int'(done_flag), 1);
    check("err_err", int'(err_flag), 1);
    check("err_busy", int'(busy), 0);
    check_banana("err_keep");

    // Single symbol; the load also clears the flags
    load(0, 8'h5A);
    check("load_clr_done", int'(done_flag), 0);
    check("load_clr_err", int'(err_flag), 0);
    decode(1, 0, 1'b0, -1, dc);
    check("z_done_cyc", dc, 515);
    rd(0, v);
    check("z_out", v, 8'h5A);

    // Zero length: immediate done, no error
    decode(0, 0, 1'b0, -1, dc);
    check("len0_done_cyc", dc, 0);
    check("len0_err", int'(err_flag), 0);

    // Stray start and en while busy are ignored
    load_nnbaaa();
    decode(6, 3, 1'b1, -1, dc);
    check("dist_done_cyc", dc, 525);
    check_banana("dist");

    // Reset during WALK (WALK edges are 519..524 for n=6), then fresh run
    decode(6, 3, 1'b0, 521, dc);
    check("abort_flag", dc, -2);
    decode(6, 3, 1'b0, -1, dc);
    check("rerun_done_cyc", dc, 525);
    check_banana("rerun");

    random_block(37, "rand37");
    random_block(1023, "rand1023");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
